// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit front end: FSM states and the
// default serial timing used by both this block and serial_tx.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    localparam int DEF_BAUD_DIVISOR = 868;
    localparam int DEF_FRAME_BITS   = 10;

    function automatic int frame_cycles(input int baud_divisor, input int frame_bits);
        return baud_divisor * frame_bits;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping modulo N; returns a one-hot grant and its index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    int j;

    // Walk offsets from far to near so the nearest request to ptr wins last.
    always_comb begin
        gnt = '0;
        idx = '0;
        j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter in front of serial_tx: accepts one byte per
// frame, pulses trigger_out and holds busy_out for the whole frame time.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BAUD_DIVISOR = DEF_BAUD_DIVISOR,
    parameter int FRAME_BITS   = DEF_FRAME_BITS,
    parameter int IW           = $clog2(NUM_REQ)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [NUM_REQ-1:0]   req_valid_in,
    input  logic [NUM_REQ*8-1:0] req_data_in,
    output logic [NUM_REQ-1:0]   req_ready_out,
    output logic                 trigger_out,
    output logic [7:0]           val_out,
    output logic                 busy_out,
    output logic [IW-1:0]        grant_id_out
);

    localparam int FRAME_CYCLES = frame_cycles(BAUD_DIVISOR, FRAME_BITS);
    localparam int CW           = $clog2(FRAME_CYCLES + 1);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        rr_ptr;
    logic [NUM_REQ-1:0]   gnt;
    logic [IW-1:0]        gnt_idx;
    logic                 fire;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req (req_valid_in),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign req_ready_out = (state == IDLE) ? gnt : '0;
    assign fire          = |(req_valid_in & req_ready_out);

    // WAIT leaves on the cycle the counter steps 1 -> 0, so the frame spans
    // exactly FRAME_CYCLES busy cycles including LAUNCH.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= IDLE;
            cnt          <= '0;
            rr_ptr       <= '0;
            trigger_out  <= 1'b0;
            busy_out     <= 1'b0;
            val_out      <= 8'h00;
            grant_id_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    trigger_out <= 1'b0;
                    if (fire) begin
                        val_out      <= req_data_in[int'(gnt_idx)*8 +: 8];
                        grant_id_out <= gnt_idx;
                        rr_ptr       <= IW'((int'(gnt_idx) + 1) % NUM_REQ);
                        trigger_out  <= 1'b1;
                        busy_out     <= 1'b1;
                        state        <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    trigger_out <= 1'b0;
                    cnt         <= CW'(FRAME_CYCLES - 1);
                    state       <= WAIT;
                end
                WAIT: begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        busy_out <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    trigger_out <= 1'b0;
                    busy_out    <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of byte requesters, range 2..8.
REQ-002 SHALL have parameter BAUD_DIVISOR, default 868: clk_in cycles per UART bit (100 MHz / 115200), matching the downstream serial_tx.
REQ-003 SHALL have parameter FRAME_BITS, default 10: bits per frame (start + 8 data + stop).
REQ-004 SHALL have port clk_in, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n_in, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid_in, input, NUM_REQ: per-requester byte-available flag.
REQ-007 SHALL have port req_data_in, input, NUM_REQ*8: requester i byte at bits [8i+7:8i].
REQ-008 SHALL have port req_ready_out, output, NUM_REQ: per-requester accept; a transfer is valid&ready in the same cycle.
REQ-009 SHALL have port trigger_out, output, 1: one-cycle launch pulse to serial_tx trigger_in.
REQ-010 SHALL have port val_out, output, 8: byte to serial_tx val_in, stable while busy_out is high.
REQ-011 SHALL have port busy_out, output, 1: a frame is in flight.
REQ-012 SHALL have port grant_id_out, output, $clog2(NUM_REQ): index of the last accepted requester.

Function
REQ-013 SHALL define FRAME_CYCLES = BAUD_DIVISOR*FRAME_BITS; frame counter width = $clog2(FRAME_CYCLES+1).
REQ-014 SHALL implement an FSM with states IDLE, LAUNCH, WAIT.
REQ-015 IDLE: req_ready_out is combinationally one-hot on the first requester with valid high, searching round-robin from rr_ptr upward and wrapping modulo NUM_REQ; it is all-zero when no valid is high.
REQ-016 IDLE -> LAUNCH on a transfer at cycle t; the byte latches into val_out, the index into grant_id_out, and rr_ptr = (index+1) mod NUM_REQ.
REQ-017 LAUNCH, cycle t+1: trigger_out = 1 for exactly this cycle; the counter loads FRAME_CYCLES-1; go to WAIT.
REQ-018 WAIT: the counter decrements each cycle; at 0 go to IDLE, so IDLE is re-entered at cycle t+FRAME_CYCLES+1.
REQ-019 busy_out SHALL be high from t+1 through t+FRAME_CYCLES inclusive, i.e. in LAUNCH and WAIT.
REQ-020 req_ready_out SHALL be all-zero outside IDLE; valid held during a frame is neither accepted nor lost.
REQ-021 Requesters hold valid and data until ready; a valid dropped before ready is ignored without error.
REQ-022 Simultaneous valids: exactly one grant per frame; a continuously requesting requester waits at most NUM_REQ-1 frames.
REQ-023 A sole active requester SHALL be granted back-to-back frames with a 1-cycle IDLE gap.
REQ-024 val_out and grant_id_out SHALL hold their value between frames.

Reset
REQ-025 On rst_n_in low, immediately: state = IDLE, counter = 0, rr_ptr = 0, trigger_out = 0, busy_out = 0, val_out = 8'h00, grant_id_out = 0; req_ready_out follows the IDLE rule.
REQ-026 Reset mid-frame SHALL abort the frame with no trigger pulse; serial_tx is reset by the same system reset.
REQ-027 The first grant after reset release SHALL be no earlier than the first rising clk_in edge with rst_n_in high.

Structure
REQ-028 State enum, default BAUD_DIVISOR and FRAME_BITS SHALL live in shared package uart_pkg.
REQ-029 The round-robin pick SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot grant plus index).
REQ-030 serial_tx SHALL NOT be instantiated inside this block; the top level wires trigger_out and val_out to it.

Verification (BAUD_DIVISOR=4, FRAME_BITS=10, so FRAME_CYCLES=40; NUM_REQ=4)
REQ-031 Reset: rst_n_in low mid-WAIT -> busy_out = 0 and val_out = 00 within the same cycle, with no trigger.
REQ-032 Single request: req 2 sends 8'hA5 at cycle t -> trigger_out high at t+1 only, val_out = A5, grant_id_out = 2, busy_out high for 40 cycles, ready again at t+41.
REQ-033 Contention: reqs 0..3 all valid with bytes 10,11,12,13 -> trigger order 0,1,2,3, then 0, triggers 41 cycles apart.
REQ-034 Wrap: after a req 3 grant, valids on reqs 0 and 3 -> req 0 is granted next.
REQ-035 Busy blocking: req 1 asserts valid during WAIT -> req_ready_out stays 0 until IDLE, then the transfer occurs in the first IDLE cycle.
REQ-036 Serial check: instantiate with serial_tx; 8'h3C from req 0 -> data_out shows start bit 0, LSB-first 0,0,1,1,1,1,0,0, stop bit 1, each bit 4 cycles wide.
